data_mem_controller: RTL and testbench

//   MEM-stage data memory controller. Formats loads and stores for byte, half and word accesses.

---
 rtl/data_mem_controller.sv | 176 +++++++++++++++++
 tb/tb_data_mem_controller.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_controller.sv
// MEM-stage data memory controller: byte/half/word load-store formatting,
// request/ack handshake with data memory, and the LL/SC link bit.
module data_mem_controller #(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] DataIn,
  input  logic [31:0] Address,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemByte,
  input  logic        MemHalf,
  input  logic        MemSignExtend,
  input  logic        LLSC,
  input  logic        Eret,
  input  logic        M_Stall,
  input  logic [31:0] DataMem_In,
  input  logic        DataMem_Ack,
  output logic [31:0] DataOut,
  output logic [31:0] DataMem_Out,
  output logic        DataMem_Read,
  output logic [3:0]  DataMem_Write,
  output logic [29:0] DataMem_Address,
  output logic        M_Stall_Controller,
  output logic        EXC_AdEL,
  output logic        EXC_AdES
);

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 30;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t          state_q, state_d;
  logic            llbit_q;
  logic [DW-1:0]   data_q;

  logic            misaligned, sc_op, ll_op, sc_fail, req;
  logic [DW-1:0]   st_data;
  logic [3:0]      st_we;

  // operands frozen while an access is outstanding
  logic            read_q, byte_q, half_q, sext_q, ll_q, sc_q;
  logic [3:0]      we_q;
  logic [DW-1:0]   wdata_q;
  logic [AW-1:0]   addr_q;
  logic [1:0]      lo_q;

  logic            busy, active, ack_take;
  logic            op_read, op_byte, op_half, op_sext, op_ll, op_sc;
  logic [3:0]      op_we;
  logic [DW-1:0]   op_wdata;
  logic [AW-1:0]   op_addr;
  logic [1:0]      op_lo;

  // alignment check; byte accesses are always aligned
  always_comb begin
    misaligned = 1'b0;
    if (!MemByte) misaligned = MemHalf ? Address[0] : (Address[1:0] != 2'b00);
  end

  assign EXC_AdEL = MemRead & misaligned;
  assign EXC_AdES = MemWrite & misaligned;
  assign sc_op    = MemWrite & LLSC;
  assign ll_op    = MemRead & LLSC;
  assign sc_fail  = sc_op & ~llbit_q;
  assign req      = (MemRead | MemWrite) & ~misaligned & ~sc_fail;

  // store lane placement
  always_comb begin
    st_data = DataIn;
    st_we   = 4'b1111;
    if (MemByte) begin
      st_data = {4{DataIn[7:0]}};
      st_we   = BIG_ENDIAN ? (4'b1000 >> Address[1:0]) : (4'b0001 << Address[1:0]);
    end else if (MemHalf) begin
      st_data = {2{DataIn[15:0]}};
      st_we   = (Address[1] ^ !BIG_ENDIAN) ? 4'b0011 : 4'b1100;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      read_q  <= 1'b0;
      we_q    <= 4'b0;
      wdata_q <= '0;
      addr_q  <= '0;
      lo_q    <= 2'b0;
      byte_q  <= 1'b0;
      half_q  <= 1'b0;
      sext_q  <= 1'b0;
      ll_q    <= 1'b0;
      sc_q    <= 1'b0;
    end else if (state_q == IDLE && req) begin
      read_q  <= MemRead;
      we_q    <= MemWrite ? st_we : 4'b0;
      wdata_q <= st_data;
      addr_q  <= Address[31:2];
      lo_q    <= Address[1:0];
      byte_q  <= MemByte;
      half_q  <= MemHalf;
      sext_q  <= MemSignExtend;
      ll_q    <= ll_op;
      sc_q    <= sc_op;
    end
  end

  assign busy     = (state_q == BUSY);
  assign op_read  = busy ? read_q  : MemRead;
  assign op_we    = busy ? we_q    : (MemWrite ? st_we : 4'b0);
  assign op_wdata = busy ? wdata_q : st_data;
  assign op_addr  = busy ? addr_q  : Address[31:2];
  assign op_lo    = busy ? lo_q    : Address[1:0];
  assign op_byte  = busy ? byte_q  : MemByte;
  assign op_half  = busy ? half_q  : MemHalf;
  assign op_sext  = busy ? sext_q  : MemSignExtend;
  assign op_ll    = busy ? ll_q    : ll_op;
  assign op_sc    = busy ? sc_q    : sc_op;

  assign active   = ~reset & ((state_q == IDLE && req) | busy);
  assign ack_take = active & DataMem_Ack;

  function automatic logic [DW-1:0] fmt_load(input logic [DW-1:0] d, input logic [1:0] lo,
                                             input logic b, input logic h, input logic s);
    logic [1:0]  bi;
    logic [7:0]  bv;
    logic [15:0] hv;
    bi = BIG_ENDIAN ? ~lo : lo;
    bv = d[{bi, 3'b000} +: 8];
    hv = (BIG_ENDIAN ? ~lo[1] : lo[1]) ? d[31:16] : d[15:0];
    if (b)      fmt_load = {{24{s & bv[7]}}, bv};
    else if (h) fmt_load = {{16{s & hv[15]}}, hv};
    else        fmt_load = d;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = DataMem_Ack ? (M_Stall ? DONE : IDLE) : BUSY;
      BUSY:    if (DataMem_Ack) state_d = M_Stall ? DONE : IDLE;
      DONE:    if (!M_Stall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    DataMem_Read       = active & op_read;
    DataMem_Write      = active ? op_we : 4'b0;
    DataMem_Address    = op_addr;
    DataMem_Out        = op_wdata;
    M_Stall_Controller = active & ~DataMem_Ack;
    if (state_q == DONE) DataOut = data_q;
    else if (op_sc)      DataOut = {31'b0, (busy | ~sc_fail)};
    else                 DataOut = fmt_load(DataMem_In, op_lo, op_byte, op_half, op_sext);
  end

  // result hold register and link bit; Eret wins over a same-cycle LL completion
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      llbit_q <= 1'b0;
    end else begin
      if (ack_take) data_q <= DataOut;
      if (Eret)                    llbit_q <= 1'b0;
      else if (ack_take && op_ll)  llbit_q <= 1'b1;
      else if (ack_take && op_sc)  llbit_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_mem_controller.sv
// Scoreboard bench for data_mem_controller: expected results are queued when an
// access is driven and compared when the memory handshake completes.
module tb_data_mem_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] DataIn, Address, DataMem_In;
  logic        MemRead, MemWrite, MemByte, MemHalf, MemSignExtend, LLSC, Eret;
  logic        DataMem_Ack, ext_stall, m_stall;
  logic [31:0] DataOut, DataMem_Out;
  logic        DataMem_Read, M_Stall_Controller, EXC_AdEL, EXC_AdES;
  logic [3:0]  DataMem_Write;
  logic [29:0] DataMem_Address;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        chk;
    logic        rd;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [29:0] addr;
    logic        el;
    logic        es;
  } exp_t;

  exp_t sb[$];

  always #5 clock = ~clock;
  assign m_stall = M_Stall_Controller | ext_stall;

  data_mem_controller #(.BIG_ENDIAN(1'b1)) dut (
    .clock(clock), .reset(reset), .DataIn(DataIn), .Address(Address),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemByte(MemByte), .MemHalf(MemHalf),
    .MemSignExtend(MemSignExtend), .LLSC(LLSC), .Eret(Eret), .M_Stall(m_stall),
    .DataMem_In(DataMem_In), .DataMem_Ack(DataMem_Ack), .DataOut(DataOut),
    .DataMem_Out(DataMem_Out), .DataMem_Read(DataMem_Read), .DataMem_Write(DataMem_Write),
    .DataMem_Address(DataMem_Address), .M_Stall_Controller(M_Stall_Controller),
    .EXC_AdEL(EXC_AdEL), .EXC_AdES(EXC_AdES)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] data, input logic chk, input logic rd,
                              input logic [3:0] we, input logic [31:0] wdata,
                              input logic [29:0] addr, input logic el, input logic es);
    exp_t e;
    e.data = data; e.chk = chk; e.rd = rd; e.we = we;
    e.wdata = wdata; e.addr = addr; e.el = el; e.es = es;
    return e;
  endfunction

  task automatic idle_inputs();
    MemRead = 0; MemWrite = 0; MemByte = 0; MemHalf = 0; MemSignExtend = 0;
    LLSC = 0; Eret = 0; DataMem_Ack = 0; DataIn = '0; Address = '0;
  endtask

  task automatic set_op(input logic rd, input logic wr, input logic b, input logic h,
                        input logic sx, input logic llsc, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] mem_in);
    @(posedge clock); #1;
    MemRead = rd; MemWrite = wr; MemByte = b; MemHalf = h; MemSignExtend = sx;
    LLSC = llsc; Address = a; DataIn = d; DataMem_In = mem_in;
  endtask

  // lat < 0: no request expected; freeze > 0: pipeline held after completion
  task automatic run(input int lat, input int freeze, input exp_t ex);
    exp_t e;
    int   cyc, stalls;
    bit   done;
    sb.push_back(ex);
    ext_stall   = (freeze > 0);
    DataMem_Ack = (lat == 0);
    cyc = 0; stalls = 0; done = 0;
    while (!done && cyc < 64) begin
      @(negedge clock);
      if (cyc == 0) begin
        e = sb[0];
        check("read_req", 32'(DataMem_Read), 32'(e.rd));
        check("write_en", 32'(DataMem_Write), 32'(e.we));
        if (e.rd || e.we != 4'b0) check("word_addr", 32'(DataMem_Address), 32'(e.addr));
        if (e.we != 4'b0) check("store_data", DataMem_Out, e.wdata);
        check("exc_adel", 32'(EXC_AdEL), 32'(e.el));
        check("exc_ades", 32'(EXC_AdES), 32'(e.es));
      end
      if (lat < 0) begin
        e = sb.pop_front();
        check("no_stall", 32'(M_Stall_Controller), 32'd0);
        if (e.chk) check("data_out", DataOut, e.data);
        done = 1;
      end else if (DataMem_Ack) begin
        e = sb.pop_front();
        if (e.chk) check("data_out", DataOut, e.data);
        check("stall_at_ack", 32'(M_Stall_Controller), 32'd0);
        check("stall_cycles", 32'(stalls), 32'(lat));
        done = 1;
      end else if (M_Stall_Controller) begin
        stalls++;
      end
      @(posedge clock); #1;
      cyc++;
      if (done) DataMem_Ack = 0;
      else if (cyc == lat) DataMem_Ack = 1;
    end
    if (!done) begin
      check("ack_timeout", 32'd0, 32'd1);
      e = sb.pop_front();
    end
    for (int f = 0; f < freeze; f++) begin
      DataMem_In  = ~DataMem_In;
      DataMem_Ack = 1;
      @(negedge clock);
      check("frozen_read", 32'(DataMem_Read), 32'd0);
      check("frozen_write", 32'(DataMem_Write), 32'd0);
      check("frozen_stall", 32'(M_Stall_Controller), 32'd0);
      check("frozen_data", DataOut, e.data);
      @(posedge clock); #1;
    end
    if (freeze > 0) begin
      DataMem_Ack = 0;
      ext_stall   = 0;
      @(posedge clock); #1;
      idle_inputs();
      DataMem_In = 32'h1357_2468;
      @(negedge clock);
      check("idle_data", DataOut, 32'h1357_2468);
      check("idle_read", 32'(DataMem_Read), 32'd0);
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    ext_stall  = 0;
    DataMem_In = '0;
    reset      = 1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_read", 32'(DataMem_Read), 32'd0);
    check("rst_write", 32'(DataMem_Write), 32'd0);
    check("rst_stall", 32'(M_Stall_Controller), 32'd0);
    check("rst_data", DataOut, 32'd0);
    @(posedge clock); #1;
    reset = 0;

    // loads: rd wr b h sx llsc addr din mem_in
    set_op(1, 0, 0, 0, 0, 0, 32'h100, 32'h0, 32'hDEAD_BEEF);
    run(0, 0, mk(32'hDEAD_BEEF, 1, 1, 4'b0, 32'h0, 30'h40, 0, 0));
    set_op(1, 0, 1, 0, 1, 0, 32'h103, 32'h0, 32'h0000_00F0);
    run(3, 0, mk(32'hFFFF_FFF0, 1, 1, 4'b0, 32'h0, 30'h40, 0, 0));
    set_op(1, 0, 1, 0, 0, 0, 32'h100, 32'h0, 32'h8A00_0000);
    run(1, 0, mk(32'h0000_008A, 1, 1, 4'b0, 32'h0, 30'h40, 0, 0));
    set_op(1, 0, 0, 1, 1, 0, 32'h102, 32'h0, 32'h1234_8001);
    run(2, 0, mk(32'hFFFF_8001, 1, 1, 4'b0, 32'h0, 30'h40, 0, 0));
    set_op(1, 0, 0, 1, 0, 0, 32'h100, 32'h0, 32'h8001_1234);
    run(0, 0, mk(32'h0000_8001, 1, 1, 4'b0, 32'h0, 30'h40, 0, 0));

    // stores
    set_op(0, 1, 0, 1, 0, 0, 32'h102, 32'h0000_1234, 32'h0);
    run(0, 0, mk(32'h0, 0, 0, 4'b0011, 32'h1234_1234, 30'h40, 0, 0));
    set_op(0, 1, 1, 0, 0, 0, 32'h101, 32'h0000_00AB, 32'h0);
    run(1, 0, mk(32'h0, 0, 0, 4'b0100, 32'hABAB_ABAB, 30'h40, 0, 0));
    set_op(0, 1, 0, 0, 0, 0, 32'h104, 32'hCAFE_F00D, 32'h0);
    run(2, 0, mk(32'h0, 0, 0, 4'b1111, 32'hCAFE_F00D, 30'h41, 0, 0));

    // misaligned accesses
    set_op(1, 0, 0, 1, 0, 0, 32'h101, 32'h0, 32'h0);
    run(-1, 0, mk(32'h0, 0, 0, 4'b0, 32'h0, 30'h0, 1, 0));
    set_op(0, 1, 0, 0, 0, 0, 32'h102, 32'h5555_5555, 32'h0);
    run(-1, 0, mk(32'h0, 0, 0, 4'b0, 32'h0, 30'h0, 0, 1));

    // completion while the pipeline is frozen
    set_op(1, 0, 0, 0, 0, 0, 32'h200, 32'h0, 32'h55AA_55AA);
    run(1, 4, mk(32'h55AA_55AA, 1, 1, 4'b0, 32'h0, 30'h80, 0, 0));

    // LL then SC succeeds, then a second SC fails
    set_op(1, 0, 0, 0, 0, 1, 32'h300, 32'h0, 32'h0BAD_CAFE);
    run(1, 0, mk(32'h0BAD_CAFE, 1, 1, 4'b0, 32'h0, 30'hC0, 0, 0));
    set_op(0, 1, 0, 0, 0, 1, 32'h300, 32'h0000_0077, 32'h0);
    run(1, 0, mk(32'h1, 1, 0, 4'b1111, 32'h0000_0077, 30'hC0, 0, 0));
    set_op(0, 1, 0, 0, 0, 1, 32'h300, 32'h0000_0088, 32'h0);
    run(-1, 0, mk(32'h0, 1, 0, 4'b0, 32'h0, 30'h0, 0, 0));

    // LL, Eret, SC fails
    set_op(1, 0, 0, 0, 0, 1, 32'h304, 32'h0, 32'h0000_1111);
    run(0, 0, mk(32'h0000_1111, 1, 1, 4'b0, 32'h0, 30'hC1, 0, 0));
    @(posedge clock); #1; Eret = 1;
    @(posedge clock); #1; Eret = 0;
    set_op(0, 1, 0, 0, 0, 1, 32'h304, 32'h0000_0099, 32'h0);
    run(-1, 0, mk(32'h0, 1, 0, 4'b0, 32'h0, 30'h0, 0, 0));

    // LL, then reset while a load is outstanding clears request and link bit
    set_op(1, 0, 0, 0, 0, 1, 32'h500, 32'h0, 32'h0000_2222);
    run(0, 0, mk(32'h0000_2222, 1, 1, 4'b0, 32'h0, 30'h140, 0, 0));
    set_op(1, 0, 0, 0, 0, 0, 32'h400, 32'h0, 32'h0000_3333);
    DataMem_Ack = 0;
    @(negedge clock);
    check("busy_stall", 32'(M_Stall_Controller), 32'd1);
    @(posedge clock); #1;
    reset = 1;
    #1;
    check("rst_busy_read", 32'(DataMem_Read), 32'd0);
    check("rst_busy_stall", 32'(M_Stall_Controller), 32'd0);
    @(negedge clock);
    check("rst_next_read", 32'(DataMem_Read), 32'd0);
    check("rst_next_stall", 32'(M_Stall_Controller), 32'd0);
    idle_inputs();
    @(posedge clock); #1;
    reset = 0;
    set_op(0, 1, 0, 0, 0, 1, 32'h500, 32'h0000_0042, 32'h0);
    run(-1, 0, mk(32'h0, 1, 0, 4'b0, 32'h0, 30'h0, 0, 0));

    repeat (2) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
